eot_mailbox: RTL and testbench

EOT_MAILBOX -- requirements
Module: eot_mailbox

---
 rtl/eot_mailbox_pkg.sv | 29 ++
 rtl/eot_mailbox_if.sv | 24 ++
 rtl/eot_mailbox_watchdog.sv | 45 ++++
 rtl/eot_mailbox.sv | 126 ++++++++++++
 tb/tb_eot_mailbox.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eot_mailbox_pkg.sv
// Shared definitions for the end-of-test mailbox: register offsets,
// the watchdog flag value, the FSM state type and a byte-merge helper.
package eot_mailbox_pkg;

   localparam logic [3:0]  OFF_FLAG   = 4'h0;
   localparam logic [3:0]  OFF_RESULT = 4'h4;
   localparam logic [3:0]  OFF_CYCLES = 4'h8;
   localparam logic [3:0]  OFF_CTRL   = 4'hC;

   localparam logic [31:0] EOT_TIMEOUT_FLAG = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_RUN,
      ST_DONE
   } eot_state_e;

   // Merge write data into an existing word, one byte per enable bit.
   function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/eot_mailbox_if.sv
// Core data-bus interface for the end-of-test mailbox.
// master: the core issuing requests; slave: the mailbox responding.
interface eot_mailbox_if;

   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;

   modport master (
      output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o
   );

   modport slave (
      input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o
   );

endinterface

// File: rtl/eot_mailbox_watchdog.sv
// Saturating run-cycle counter with watchdog expiry compare.
// Expiry is only produced when EOT_WATCHDOG_EN is defined.
module eot_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        run_i,
   input  logic        clear_i,
   output logic [31:0] count_o,
   output logic        expire_o
);

`ifdef EOT_WATCHDOG_EN
   localparam logic WD_EN = 1'b1;
`else
   localparam logic WD_EN = 1'b0;
`endif

   // Fires on the edge that moves the count to TIMEOUT_CYCLES-1, so the
   // flag and the final count land together.
   localparam logic [31:0] EXPIRE_AT = 32'(TIMEOUT_CYCLES - 2);

   logic [31:0] count_q, count_d;

   // Count while running, clear on request, hold at all-ones.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (run_i && (count_q != '1)) begin
         count_d = count_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o  = count_q;
   assign expire_o = WD_EN && run_i && (count_q >= EXPIRE_AT);

endmodule

// File: rtl/eot_mailbox.sv
// End-of-test mailbox: FLAG/RESULT/CYCLES/CTRL register window on the
// core data bus, zero-wait-state grant, one-cycle response.
// Optional watchdog enabled by macro EOT_WATCHDOG_EN.
module eot_mailbox
   import eot_mailbox_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic          clk_i,
   input  logic          rst_i,
   eot_mailbox_if.slave  bus,
   output logic [31:0]   mem_flag_o,
   output logic [31:0]   mem_result_o,
   output logic          timeout_o
);

   eot_state_e  state_q, state_d;
   logic [31:0] flag_q, flag_d;
   logic [31:0] result_q, result_d;
   logic        timeout_q, timeout_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   logic [27:0] off_hi;
   logic [1:0]  off_word;
   logic        in_win, rd_hit, wr_hit;
   logic        flag_wr, result_wr, ctrl_clr;
   logic        run;
   logic [31:0] cycles;
   logic        expire;

   assign run = (state_q == ST_RUN);

   eot_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .run_i   (run),
      .clear_i (ctrl_clr),
      .count_o (cycles),
      .expire_o(expire)
   );

   // Address decode relative to the window base; byte lane bits ignored.
   always_comb begin
      {off_hi, off_word} = 30'((bus.data_addr_i - BASE_ADDR) >> 2);
      in_win    = bus.data_req_i && (off_hi == '0);
      wr_hit    = in_win && bus.data_we_i;
      rd_hit    = in_win && !bus.data_we_i;
      flag_wr   = wr_hit && (off_word == OFF_FLAG[3:2]) && (bus.data_be_i != '0);
      result_wr = wr_hit && (off_word == OFF_RESULT[3:2]);
      ctrl_clr  = wr_hit && (off_word == OFF_CTRL[3:2]) &&
                  bus.data_be_i[0] && bus.data_wdata_i[0];
   end

   // Register and FSM update: clear beats everything, bus write beats expiry.
   always_comb begin
      state_d   = state_q;
      flag_d    = flag_q;
      result_d  = result_q;
      timeout_d = timeout_q;
      if (ctrl_clr) begin
         state_d   = ST_RUN;
         flag_d    = '0;
         result_d  = '0;
         timeout_d = 1'b0;
      end else if (state_q == ST_RUN) begin
         if (result_wr) result_d = apply_be(result_q, bus.data_wdata_i, bus.data_be_i);
         if (flag_wr) begin
            flag_d = apply_be(flag_q, bus.data_wdata_i, bus.data_be_i);
         end else if (expire) begin
            flag_d    = EOT_TIMEOUT_FLAG;
            timeout_d = 1'b1;
         end
         if (flag_d != '0) state_d = ST_DONE;
      end
   end

   // Response for the request granted this cycle; writes return zero.
   always_comb begin
      rvalid_d = bus.data_req_i;
      rdata_d  = '0;
      if (rd_hit) begin
         case (off_word)
            OFF_FLAG[3:2]:   rdata_d = flag_q;
            OFF_RESULT[3:2]: rdata_d = result_q;
            OFF_CYCLES[3:2]: rdata_d = cycles;
            default:         rdata_d = '0;
         endcase
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         flag_q    <= '0;
         result_q  <= '0;
         timeout_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         flag_q    <= flag_d;
         result_q  <= result_d;
         timeout_q <= timeout_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.data_gnt_o    = bus.data_req_i;
   assign bus.data_rvalid_o = rvalid_q;
   assign bus.data_rdata_o  = rdata_q;
   assign mem_flag_o        = flag_q;
   assign mem_result_o      = result_q;

`ifdef EOT_WATCHDOG_EN
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_eot_mailbox.sv
// Self-checking bench for eot_mailbox: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_eot_mailbox;

   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam int unsigned TMO  = 100;
`ifdef EOT_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_flag, mem_result;
   logic        timeout;

   eot_mailbox_if bus();

   eot_mailbox #(
      .BASE_ADDR     (BASE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .mem_flag_o  (mem_flag),
      .mem_result_o(mem_result),
      .timeout_o   (timeout)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      bus.data_req_i   = req;
      bus.data_we_i    = we;
      bus.data_addr_i  = addr;
      bus.data_be_i    = be;
      bus.data_wdata_i = wd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_flag, m_result, m_cycles, m_rdata;
   bit          m_done, m_to, m_rvalid, m_was_rd;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_v & ~mask) | (wd & mask);
   endfunction

   task automatic model_reset();
      m_flag = 0; m_result = 0; m_cycles = 0; m_rdata = 0;
      m_done = 0; m_to = 0; m_rvalid = 0; m_was_rd = 0;
   endtask

   // Advance the model by one clock edge using the inputs on the bus now.
   task automatic model_edge();
      logic [31:0] off, new_cyc;
      bit hit, is_wr;
      int r;
      off   = bus.data_addr_i - BASE;
      hit   = bus.data_req_i && (off < 32'd16);
      r     = hit ? int'(off[3:2]) : -1;
      is_wr = hit && bus.data_we_i;
      m_rvalid = bus.data_req_i;
      m_was_rd = bus.data_req_i && !bus.data_we_i;
      m_rdata  = 0;
      if (hit && !bus.data_we_i) begin
         if (r == 0) m_rdata = m_flag;
         else if (r == 1) m_rdata = m_result;
         else if (r == 2) m_rdata = m_cycles;
      end
      if (is_wr && r == 3 && bus.data_be_i[0] && bus.data_wdata_i[0]) begin
         m_flag = 0; m_result = 0; m_cycles = 0; m_to = 0; m_done = 0;
      end else if (!m_done) begin
         new_cyc = (m_cycles == 32'hFFFF_FFFF) ? m_cycles : m_cycles + 1;
         if (is_wr && r == 1) m_result = merge(m_result, bus.data_wdata_i, bus.data_be_i);
         if (is_wr && r == 0 && bus.data_be_i != 0)
            m_flag = merge(m_flag, bus.data_wdata_i, bus.data_be_i);
         else if (WD && new_cyc >= TMO - 1) begin
            m_flag = 32'hFFFF_FFFF;
            m_to   = 1;
         end
         m_cycles = new_cyc;
         if (m_flag != 0) m_done = 1;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] off;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rdata;
      logic [31:0] exp_flag;
      logic [31:0] exp_result;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic req, input logic we, input logic [31:0] off,
                               input logic [3:0] be, input logic [31:0] wd, input logic chk_rd,
                               input logic [31:0] rd, input logic [31:0] fl, input logic [31:0] rs);
      vec_t v;
      v.req = req; v.we = we; v.off = off; v.be = be; v.wdata = wd;
      v.chk_rd = chk_rd; v.exp_rdata = rd; v.exp_flag = fl; v.exp_result = rs;
      return v;
   endfunction

   initial begin
      #(1_000_000);
      $display("FAIL global_timeout: simulation exceeded time bound");
      $fatal(1, "time bound");
   end

   initial begin
      int seen;
      idle();

      // reset state
      #1;
      chk("reset_rvalid",  32'(bus.data_rvalid_o), 32'h0);
      chk("reset_rdata",   bus.data_rdata_o, 32'h0);
      chk("reset_flag",    mem_flag, 32'h0);
      chk("reset_result",  mem_result, 32'h0);
      chk("reset_timeout", 32'(timeout), 32'h0);

      // ---- table ----
      tbl.push_back(mk(1, 1, 32'h4,  4'hF, 32'd42,       0, 0, 0, 42));
      tbl.push_back(mk(1, 1, 32'h0,  4'hF, 32'd1,        0, 0, 1, 42));
      tbl.push_back(mk(1, 1, 32'h0,  4'hF, 32'd5,        0, 0, 1, 42));
      tbl.push_back(mk(1, 1, 32'h4,  4'hF, 32'd7,        0, 0, 1, 42));
      tbl.push_back(mk(1, 0, 32'h0,  4'hF, 32'd0,        1, 1, 1, 42));
      tbl.push_back(mk(1, 0, 32'h4,  4'hF, 32'd0,        1, 42, 1, 42));
      tbl.push_back(mk(1, 0, 32'hC,  4'hF, 32'd0,        1, 0, 1, 42));
      tbl.push_back(mk(1, 0, 32'h20, 4'hF, 32'd0,        1, 0, 1, 42));
      tbl.push_back(mk(1, 0, 32'hFFFF_FFFC, 4'hF, 32'd0, 1, 0, 1, 42));
      tbl.push_back(mk(1, 1, 32'hC,  4'hF, 32'd1,        0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h0,  4'hF, 32'd5,        0, 0, 5, 0));
      tbl.push_back(mk(1, 1, 32'hC,  4'hF, 32'd1,        0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 32'h4,  4'h5, 32'hAABB_CCDD, 0, 0, 0, 32'h00BB_00DD));
      tbl.push_back(mk(1, 0, 32'h4,  4'hF, 32'd0,        1, 32'h00BB_00DD, 0, 32'h00BB_00DD));
      tbl.push_back(mk(1, 1, 32'h0,  4'h0, 32'd9,        0, 0, 0, 32'h00BB_00DD));
      tbl.push_back(mk(1, 1, 32'h20, 4'hF, 32'd9,        0, 0, 0, 32'h00BB_00DD));
      tbl.push_back(mk(0, 0, 32'h0,  4'h0, 32'd0,        1, 0, 0, 32'h00BB_00DD));
      tbl.push_back(mk(1, 1, 32'h0,  4'hF, 32'd3,        0, 0, 3, 32'h00BB_00DD));
      tbl.push_back(mk(1, 1, 32'hC,  4'hF, 32'd2,        0, 0, 3, 32'h00BB_00DD));
      tbl.push_back(mk(1, 1, 32'hC,  4'hF, 32'd1,        0, 0, 0, 0));

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].req, tbl[i].we, BASE + tbl[i].off, tbl[i].be, tbl[i].wdata);
         #1;
         chk($sformatf("tbl%0d_gnt", i), 32'(bus.data_gnt_o), 32'(tbl[i].req));
         @(negedge clk);
         chk($sformatf("tbl%0d_rvalid", i), 32'(bus.data_rvalid_o), 32'(tbl[i].req));
         if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), bus.data_rdata_o, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_flag", i), mem_flag, tbl[i].exp_flag);
         chk($sformatf("tbl%0d_result", i), mem_result, tbl[i].exp_result);
         chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'h0);
      end
      idle();

      // ---- CYCLES read at cycle 10 ----
      do_reset();
      repeat (10) @(negedge clk);
      drive(1, 0, BASE + 32'h8, 4'hF, 0);
      #1 chk("cyc10_gnt", 32'(bus.data_gnt_o), 32'h1);
      @(negedge clk);
      chk("cyc10_rvalid", 32'(bus.data_rvalid_o), 32'h1);
      chk("cyc10_rdata", bus.data_rdata_o, 32'd10);
      idle();
      @(negedge clk);
      chk("cyc10_rvalid_drop", 32'(bus.data_rvalid_o), 32'h0);
      chk("cyc10_rdata_zero", bus.data_rdata_o, 32'h0);

      // ---- RESULT=42 then FLAG=1, CYCLES frozen ----
      do_reset();
      drive(1, 1, BASE + 32'h4, 4'hF, 32'd42);
      @(negedge clk);
      drive(1, 1, BASE + 32'h0, 4'hF, 32'd1);
      @(negedge clk);
      chk("eot_result", mem_result, 32'd42);
      chk("eot_flag", mem_flag, 32'd1);
      idle();
      repeat (5) @(negedge clk);
      drive(1, 0, BASE + 32'h8, 4'hF, 0);
      @(negedge clk);
      chk("eot_cycles_frozen", bus.data_rdata_o, 32'd2);
      idle();

      // ---- watchdog ----
`ifdef EOT_WATCHDOG_EN
      do_reset();
      seen = 0;
      for (int e = 1; e <= 200 && seen == 0; e++) begin
         @(negedge clk);
         if (mem_flag == 32'hFFFF_FFFF) seen = e;
      end
      chk("wd_expiry_cycle", 32'(seen), 32'd99);
      chk("wd_timeout", 32'(timeout), 32'h1);
      drive(1, 0, BASE + 32'h8, 4'hF, 0);
      @(negedge clk);
      chk("wd_cycles", bus.data_rdata_o, 32'd99);
      drive(1, 1, BASE + 32'hC, 4'hF, 32'd1);
      @(negedge clk);
      chk("wd_clear_flag", mem_flag, 32'h0);
      chk("wd_clear_timeout", 32'(timeout), 32'h0);
      idle();
      do_reset();
      repeat (98) @(negedge clk);
      drive(1, 1, BASE, 4'hF, 32'd3);
      @(negedge clk);
      chk("wd_coincide_flag", mem_flag, 32'd3);
      chk("wd_coincide_timeout", 32'(timeout), 32'h0);
      idle();
`else
      do_reset();
      seen = 0;
      repeat (150) @(negedge clk);
      chk("nowd_flag", mem_flag, 32'h0);
      chk("nowd_timeout", 32'(timeout), 32'h0);
      drive(1, 0, BASE + 32'h8, 4'hF, 0);
      @(negedge clk);
      chk("nowd_cycles", bus.data_rdata_o, 32'd150);
      idle();
`endif

      // ---- reset during a pending read ----
      do_reset();
      drive(1, 1, BASE, 4'hF, 32'd7);
      @(negedge clk);
      drive(1, 0, BASE, 4'hF, 0);
      #1 chk("rstmid_gnt", 32'(bus.data_gnt_o), 32'h1);
      @(posedge clk);
      #2;
      chk("rstmid_rvalid_pre", 32'(bus.data_rvalid_o), 32'h1);
      chk("rstmid_rdata_pre", bus.data_rdata_o, 32'd7);
      idle();
      rst = 1'b1;
      #1;
      chk("rstmid_rvalid", 32'(bus.data_rvalid_o), 32'h0);
      chk("rstmid_rdata", bus.data_rdata_o, 32'h0);
      chk("rstmid_flag", mem_flag, 32'h0);
      chk("rstmid_result", mem_result, 32'h0);
      chk("rstmid_timeout", 32'(timeout), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rstmid_post%0d_rvalid", i), 32'(bus.data_rvalid_o), 32'h0);
      end

      // ---- randomized traffic against the model ----
      do_reset();
      model_reset();
      for (int i = 0; i < 400; i++) begin
         logic        req, we;
         logic [31:0] addr, wd;
         logic [3:0]  be;
         int          sel;
         chk("rnd_rvalid",  32'(bus.data_rvalid_o), 32'(m_rvalid));
         if (m_rvalid && m_was_rd) chk("rnd_rdata", bus.data_rdata_o, m_rdata);
         if (!m_rvalid) chk("rnd_rdata_idle", bus.data_rdata_o, 32'h0);
         chk("rnd_flag",    mem_flag, m_flag);
         chk("rnd_result",  mem_result, m_result);
         chk("rnd_timeout", 32'(timeout), 32'(m_to));
         req = ($urandom_range(0, 9) != 0);
         we  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 7);
         case (sel)
            0, 1, 2, 3: addr = BASE + 32'(sel * 4);
            4:          addr = BASE + 32'h10;
            5:          addr = BASE - 32'h4;
            6:          addr = $urandom;
            default:    addr = BASE + 32'hC;
         endcase
         be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
         wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         drive(req, we, addr, be, wd);
         #1 chk("rnd_gnt", 32'(bus.data_gnt_o), 32'(req));
         model_edge();
         @(negedge clk);
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
